match_ctrl: RTL and testbench
=============================

# match_ctrl

Round and score controller for the two-player volleyball game. Sits downstream of the physics engine: consumes its per-frame `valid`/`game_over`/`winner` outputs, keeps the score, and gates the physics frame strobe to freeze play during serve and point banners. It also declares the match winner and waits for a restart.

## Interface
Parameters:
- `WIN_SCORE`, 7: points needed to win the match. Range 1..15.
- `SERVE_FRAMES`, 60: frames that play stays frozen before each serve.
- `POINT_FRAMES`, 90: frames that play stays frozen after a point.
- `SCORE_W`, 4: score counter width. Must satisfy 2^SCORE_W > WIN_SCORE.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `tick`  in  1  60 Hz one-cycle frame strobe from the frame tick generator.
- `frame_valid`  in  1  physics `valid`; a one-cycle pulse after each physics update.
- `game_over`  in  1  physics ball-grounded flag; sampled only when `frame_valid`=1.
- `winner`  in  2  physics winner code: 1 = P1, 2 = P2. Codes 0 and 3 are invalid.
- `start_btn`  in  1  debounced start/restart level.
- `phys_en`  out  1  gated frame strobe driven to the physics `en`.
- `p1_score`, `p2_score`  out  SCORE_W  current scores.
- `serve_side`  out  1  0 = P1 side, 1 = P2 side. Set to the side of the last point winner.
- `point_strobe`  out  1  one-cycle pulse when a point is registered.
- `match_over`  out  1  high while in MATCH_END.
- `match_winner`  out  2  winner code of the finished match; 0 while no match is decided.
- `state`  out  3  current FSM state, for the HUD.

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, MATCH_END=4.
- `phys_en` = `tick` & (state==PLAY). This is combinational; no other state passes ticks through.
- Frame timer: a down-counter loaded on state entry and decremented on each `tick`. It reaches 0 after exactly N ticks.
- IDLE: `start_btn`=1 → SERVE. Scores are cleared and the timer is loaded with SERVE_FRAMES.
- SERVE: timer reaches 0 → PLAY.
- PLAY: point detection uses a register `go_q`, which is updated to `game_over` on every `frame_valid`.
  - A point is registered on a `frame_valid` where `game_over`=1, `go_q`=0, and `winner`∈{1,2}.
  - On a point: increment the winner's score, set `serve_side`, pulse `point_strobe`, load the timer with POINT_FRAMES, then go to POINT.
  - Invalid winner codes are ignored; the FSM stays in PLAY.
- POINT: timer reaches 0 → MATCH_END if either score equals WIN_SCORE, otherwise SERVE (timer loaded with SERVE_FRAMES).
- MATCH_END: `match_winner` holds the side that reached WIN_SCORE. A rising edge on `start_btn` → SERVE, with scores cleared and `match_winner` set to 0.
- `start_btn` is ignored in SERVE, PLAY and POINT.
- A score never exceeds WIN_SCORE. The increment is unconditional because reaching WIN_SCORE always exits through POINT to MATCH_END.
- The physics engine resets the ball itself on the first enabled frame after `game_over`. Edge detection via `go_q` prevents that stale flag from scoring twice.

## Timing
- Reset values:
  - state=IDLE
  - `p1_score`=`p2_score`=0
  - `serve_side`=0
  - `point_strobe`=0
  - `match_over`=0
  - `match_winner`=0
  - `go_q`=0
  - timer=0
  - `phys_en`=0, because state is IDLE.
- Reset asserted mid-match returns the block to IDLE on the next edge and discards any pending point.
- Point latency: the qualifying `frame_valid` at edge k produces updated scores, `point_strobe`=1 and state=POINT at edge k+1. `point_strobe` drops at k+2.
- Once state leaves PLAY, `phys_en` is low in the same cycle.
- POINT lasts exactly POINT_FRAMES ticks; SERVE lasts exactly SERVE_FRAMES ticks.
- If `tick` and `frame_valid` coincide, each is handled independently. A point and the tick that would decrement the timer are processed in the same cycle; the timer load takes priority.
- `start_btn` edge detection uses a registered copy of `start_btn`. That copy resets to 1, so a button held through reset does not start a match.

## Structure
- Shared package `vb_pkg` holds:
  - the state enum;
  - winner codes WIN_NONE=0, WIN_P1=1, WIN_P2=2;
  - the default frame counts.
- Sub-module `frame_timer`: a loadable down-counter with inputs `load`, `load_val` and `tick`, and an output `zero`. Its width is $clog2(max(SERVE_FRAMES,POINT_FRAMES)+1).

## Test plan
- Reset, then `start_btn` pulse, then 60 ticks → state goes SERVE→PLAY and `phys_en` mirrors `tick` only in PLAY.
- In PLAY, `frame_valid` with `game_over`=1 and `winner`=2 → `p2_score`=1, `serve_side`=1, `point_strobe` high for 1 cycle, state=POINT. A second `frame_valid` with `game_over` still 1 → no further score change.
- `game_over`=1 with `winner`=3 in PLAY → scores unchanged, state stays PLAY.
- Seven P1 points with WIN_SCORE=7 → after 90 ticks in POINT, state=MATCH_END, `match_winner`=1, `match_over`=1. `start_btn` edge → scores 0, state=SERVE.
- `rst` asserted in POINT with `p1_score`=3 → next cycle: IDLE, scores 0, `phys_en`=0.
- `start_btn` held high across reset release → state remains IDLE until the button is released and pressed again.

Source files
------------

// File: rtl/vb_pkg.sv
// Shared types and constants for the volleyball round/score controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package vb_pkg;

    // Controller states; encodings are visible on the HUD state port.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_MATCH_END = 3'd4
    } state_e;

    // Winner codes shared with the physics engine.
    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    // Default match and banner lengths, in 60 Hz frames.
    localparam int WIN_SCORE_DEF    = 7;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int POINT_FRAMES_DEF = 90;
    localparam int SCORE_W_DEF      = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter of frame ticks; zero flags that the loaded count has elapsed.
// Latency: load or decrement visible one cycle after the edge; zero is combinational from the count.
// Backpressure: none; load wins over a coincident tick, and the count holds at zero.
module frame_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load beats a tick; ticks stop once the count reaches zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/match_ctrl.sv
// Round/score controller: keeps score, freezes physics during serve/point banners, declares the winner.
// Latency: a qualifying frame_valid updates score, strobe and state one cycle later; phys_en is combinational.
// Backpressure: none; frame strobes outside PLAY are simply not passed to the physics engine.
module match_ctrl
    import vb_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int POINT_FRAMES = POINT_FRAMES_DEF,
    parameter int SCORE_W      = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               frame_valid,
    input  logic               game_over,
    input  logic [1:0]         winner,
    input  logic               start_btn,
    output logic               phys_en,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               serve_side,
    output logic               point_strobe,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic [2:0]         state
);

    localparam int TMR_W = $clog2(max2(SERVE_FRAMES, POINT_FRAMES) + 1);
    localparam logic [TMR_W-1:0]   SERVE_LD = TMR_W'(SERVE_FRAMES);
    localparam logic [TMR_W-1:0]   POINT_LD = TMR_W'(POINT_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_Q    = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    logic               side_q, side_d;
    logic               strobe_q, strobe_d;
    logic [1:0]         mwin_q, mwin_d;
    logic               go_q, go_d;
    logic               start_q;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;
    logic               start_rise;
    logic               point_hit;

    // The registered button copy resets high so a button held through reset is not a press.
    assign start_rise = start_btn & ~start_q;

    // A point needs a fresh grounding (go_q low) so the physics engine's stale flag cannot score twice.
    assign point_hit = frame_valid & game_over & ~go_q &
                       ((winner == WIN_P1) | (winner == WIN_P2));

    frame_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tick),
        .zero     (tmr_zero)
    );

    // Next-state, score and timer-load decisions for the match FSM.
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        side_d   = side_q;
        strobe_d = 1'b0;
        mwin_d   = mwin_q;
        go_d     = frame_valid ? game_over : go_q;
        tmr_load = 1'b0;
        tmr_val  = SERVE_LD;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d  = ST_SERVE;
                    p1_d     = '0;
                    p2_d     = '0;
                    tmr_load = 1'b1;
                    tmr_val  = SERVE_LD;
                end
            end
            ST_SERVE: begin
                if (tmr_zero) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (point_hit) begin
                    // Reaching WIN_SCORE always leaves via POINT, so no saturation is needed.
                    if (winner == WIN_P1) begin
                        p1_d = p1_q + SCORE_W'(1);
                    end else begin
                        p2_d = p2_q + SCORE_W'(1);
                    end
                    side_d   = (winner == WIN_P2);
                    strobe_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = POINT_LD;
                    state_d  = ST_POINT;
                end
            end
            ST_POINT: begin
                if (tmr_zero) begin
                    if (p1_q == WIN_Q) begin
                        state_d = ST_MATCH_END;
                        mwin_d  = WIN_P1;
                    end else if (p2_q == WIN_Q) begin
                        state_d = ST_MATCH_END;
                        mwin_d  = WIN_P2;
                    end else begin
                        state_d  = ST_SERVE;
                        tmr_load = 1'b1;
                        tmr_val  = SERVE_LD;
                    end
                end
            end
            ST_MATCH_END: begin
                if (start_rise) begin
                    state_d  = ST_SERVE;
                    p1_d     = '0;
                    p2_d     = '0;
                    mwin_d   = WIN_NONE;
                    tmr_load = 1'b1;
                    tmr_val  = SERVE_LD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and score registers; reset drops any point in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            p1_q     <= '0;
            p2_q     <= '0;
            side_q   <= 1'b0;
            strobe_q <= 1'b0;
            mwin_q   <= WIN_NONE;
            go_q     <= 1'b0;
            start_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            side_q   <= side_d;
            strobe_q <= strobe_d;
            mwin_q   <= mwin_d;
            go_q     <= go_d;
            start_q  <= start_btn;
        end
    end

    assign phys_en      = tick & (state_q == ST_PLAY);
    assign p1_score     = p1_q;
    assign p2_score     = p2_q;
    assign serve_side   = side_q;
    assign point_strobe = strobe_q;
    assign match_over   = (state_q == ST_MATCH_END);
    assign match_winner = mwin_q;
    assign state        = state_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: random play against a score model, scoreboarded point events.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_match_ctrl;

    localparam int WIN = 7;
    localparam int SF  = 60;
    localparam int PF  = 90;
    localparam int SW  = 4;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_POINT = 3;
    localparam int S_END   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic          frame_valid;
    logic          game_over;
    logic [1:0]    winner;
    logic          start_btn;
    logic          phys_en;
    logic [SW-1:0] p1_score;
    logic [SW-1:0] p2_score;
    logic          serve_side;
    logic          point_strobe;
    logic          match_over;
    logic [1:0]    match_winner;
    logic [2:0]    state;

    typedef struct {
        int p1;
        int p2;
        int side;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Behavioural model: scores, serve side and the last sampled grounding flag.
    int m_p1;
    int m_p2;
    int m_side;
    bit m_go;

    match_ctrl #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SF),
        .POINT_FRAMES (PF),
        .SCORE_W      (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .frame_valid  (frame_valid),
        .game_over    (game_over),
        .winner       (winner),
        .start_btn    (start_btn),
        .phys_en      (phys_en),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .serve_side   (serve_side),
        .point_strobe (point_strobe),
        .match_over   (match_over),
        .match_winner (match_winner),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every point strobe must match the next expected point event.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst !== 1'b1 && point_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_point actual=strobe required=no_strobe");
            end else begin
                e = exp_q.pop_front();
                chk("pt_p1", int'(p1_score), e.p1);
                chk("pt_p2", int'(p2_score), e.p2);
                chk("pt_side", int'(serve_side), e.side);
                chk("pt_state", int'(state), S_POINT);
            end
        end
    end

    task automatic model_reset();
        m_p1   = 0;
        m_p2   = 0;
        m_side = 0;
        m_go   = 1'b0;
        exp_q.delete();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    task automatic do_tick(input int exp_en, input string nm);
        tick = 1'b1;
        @(negedge clk);
        chk(nm, int'(phys_en), exp_en);
        cyc();
        tick = 1'b0;
    endtask

    // One physics frame while playing; the model decides whether it scores.
    task automatic issue(input int go, input int win, input int tk, output bit pt);
        pt = (go == 1) && !m_go && (win == 1 || win == 2);
        m_go = (go == 1);
        if (pt) begin
            if (win == 1) m_p1++;
            else          m_p2++;
            m_side = (win == 2) ? 1 : 0;
            exp_q.push_back('{m_p1, m_p2, m_side});
        end
        frame_valid = 1'b1;
        game_over   = (go == 1);
        winner      = 2'(win);
        tick        = (tk == 1);
        @(negedge clk);
        if (tk == 1) chk("phys_en_frame", int'(phys_en), 1);
        cyc();
        frame_valid = 1'b0;
        game_over   = 1'b0;
        winner      = 2'd0;
        tick        = 1'b0;
    endtask

    task automatic serve_phase();
        for (int i = 0; i < SF; i++) begin
            start_btn = ($urandom_range(0, 1) == 1);
            gap();
            if (i == SF - 1) chk("serve_hold", int'(state), S_SERVE);
            do_tick(0, "phys_en_serve");
        end
        start_btn = 1'b0;
        cyc();
        chk("serve_to_play", int'(state), S_PLAY);
    endtask

    task automatic point_phase();
        for (int i = 0; i < PF; i++) begin
            gap();
            if (i == PF - 1) chk("point_hold", int'(state), S_POINT);
            do_tick(0, "phys_en_point");
        end
        cyc();
        if (m_p1 == WIN || m_p2 == WIN) begin
            chk("end_state", int'(state), S_END);
            chk("end_over", int'(match_over), 1);
            chk("end_winner", int'(match_winner), (m_p1 == WIN) ? 1 : 2);
            chk("end_p1", int'(p1_score), m_p1);
            chk("end_p2", int'(p2_score), m_p2);
        end else begin
            chk("next_serve", int'(state), S_SERVE);
            chk("over_low", int'(match_over), 0);
            chk("winner_none", int'(match_winner), 0);
            serve_phase();
        end
    endtask

    task automatic play_until_point(input int force_win, output bit got);
        int w;
        bit pt;
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            case ($urandom_range(0, 3))
                0: cyc();
                1: do_tick(1, "phys_en_play");
                default: begin
                    w = (force_win != 0) ? force_win : int'($urandom_range(0, 3));
                    issue(int'($urandom_range(0, 1)), w, int'($urandom_range(0, 1)), pt);
                    got = pt;
                    if (!pt) chk("stay_play", int'(state), S_PLAY);
                end
            endcase
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL play_timeout actual=no_point required=point");
        end else begin
            cyc();
            chk("strobe_drop", int'(point_strobe), 0);
            chk("in_point", int'(state), S_POINT);
        end
    endtask

    task automatic end_restart();
        start_btn = 1'b1;
        cyc();
        m_p1 = 0;
        m_p2 = 0;
        chk("restart_state", int'(state), S_SERVE);
        chk("restart_p1", int'(p1_score), 0);
        chk("restart_p2", int'(p2_score), 0);
        chk("restart_winner", int'(match_winner), 0);
        chk("restart_over", int'(match_over), 0);
        start_btn = 1'b0;
    endtask

    initial begin : drive
        bit pt;
        bit got;
        rst         = 1'b1;
        tick        = 1'b1;
        frame_valid = 1'b0;
        game_over   = 1'b0;
        winner      = 2'd0;
        start_btn   = 1'b0;
        model_reset();

        repeat (3) cyc();
        @(negedge clk);
        chk("rst_state", int'(state), S_IDLE);
        chk("rst_p1", int'(p1_score), 0);
        chk("rst_p2", int'(p2_score), 0);
        chk("rst_side", int'(serve_side), 0);
        chk("rst_strobe", int'(point_strobe), 0);
        chk("rst_over", int'(match_over), 0);
        chk("rst_winner", int'(match_winner), 0);
        chk("rst_phys_en", int'(phys_en), 0);
        cyc();
        rst  = 1'b0;
        tick = 1'b0;
        cyc();
        chk("idle_wait", int'(state), S_IDLE);

        // Match 1: directed edge cases, then random play to the end.
        start_btn = 1'b1;
        cyc();
        chk("start", int'(state), S_SERVE);
        start_btn = 1'b0;
        serve_phase();

        issue(1, 3, 0, pt);
        chk("inv_state", int'(state), S_PLAY);
        chk("inv_p1", int'(p1_score), 0);
        chk("inv_p2", int'(p2_score), 0);
        issue(0, 0, 1, pt);
        issue(1, 2, 1, pt);
        cyc();
        chk("strobe_drop", int'(point_strobe), 0);
        chk("in_point", int'(state), S_POINT);
        issue(1, 2, 0, pt);
        chk("stale_p2", int'(p2_score), 1);
        chk("stale_state", int'(state), S_POINT);
        point_phase();

        got = 1'b1;
        while (got && !(m_p1 == WIN || m_p2 == WIN)) begin
            play_until_point(0, got);
            if (got) point_phase();
        end
        end_restart();
        serve_phase();

        // Match 2: three P1 points, then reset while in POINT with the button held.
        play_until_point(1, got);
        point_phase();
        play_until_point(1, got);
        point_phase();
        play_until_point(1, got);
        chk("p1_before_rst", int'(p1_score), 3);
        rst       = 1'b1;
        start_btn = 1'b1;
        tick      = 1'b1;
        cyc();
        model_reset();
        chk("mid_rst_state", int'(state), S_IDLE);
        chk("mid_rst_p1", int'(p1_score), 0);
        chk("mid_rst_p2", int'(p2_score), 0);
        chk("mid_rst_strobe", int'(point_strobe), 0);
        @(negedge clk);
        chk("mid_rst_phys_en", int'(phys_en), 0);
        cyc();
        rst  = 1'b0;
        tick = 1'b0;
        repeat (4) cyc();
        chk("held_btn_idle", int'(state), S_IDLE);
        start_btn = 1'b0;
        cyc();
        chk("released_idle", int'(state), S_IDLE);
        start_btn = 1'b1;
        cyc();
        chk("repress_serve", int'(state), S_SERVE);
        start_btn = 1'b0;
        serve_phase();

        // Match 3: P1 takes every point.
        for (int k = 0; k < WIN; k++) begin
            play_until_point(1, got);
            point_phase();
        end
        chk("p1_match_winner", int'(match_winner), 1);
        end_restart();

        repeat (3) cyc();
        chk("queue_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

endmodule
